// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle main control unit.
// Opcode constants, the 3-bit state enum, and the datapath mux/ALU
// select encodings used by the control FSM.
// Build option: ILLEGAL_OP_TRAP_EN adds the TRAP state to the enum.
package rv_ctrl_pkg;

    // RV32I major opcodes handled by this core
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

`ifdef ILLEGAL_OP_TRAP_EN
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;
`endif

    // ALU operation select
    localparam logic [2:0] ALU_FUNCT = 3'b000;  // decode from funct3/funct7
    localparam logic [2:0] ALU_LD    = 3'b001;  // load address add
    localparam logic [2:0] ALU_ST    = 3'b010;  // store address add
    localparam logic [2:0] ALU_BR    = 3'b011;  // branch compare subtract
    localparam logic [2:0] ALU_PASSB = 3'b100;  // pass operand B (lui)
    localparam logic [2:0] ALU_ADD   = 3'b101;  // plain add

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    // Register write-back source select
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // True for every opcode the FSM knows how to sequence
    function automatic logic op_known(input logic [6:0] opc);
        logic known;
        case (opc)
            OP_R, OP_I, OP_LW, OP_SW,
            OP_BEQ, OP_LUI, OP_AUIPC, OP_JAL: known = 1'b1;
            default:                          known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/multicycle_control_unit.sv
// Multi-cycle main control FSM for the RV32I core.
// Sequences FETCH/DECODE/EXEC/MEM/WB per instruction, drives datapath
// enables and mux selects, stalls on the shared memory via mem_req/mem_ready
// and counts retired instructions.
// Build option: ILLEGAL_OP_TRAP_EN -- unknown opcodes lock the FSM in TRAP and
// set the sticky illegal flag; without it unknown opcodes retire as NOPs.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE | compute oldPC+imm (branch/jal target) into ALUOut
// EXEC   | per-opcode ALU work; beq and jal complete here
// MEM    | data access at ALUOut (lw read / sw write), wait for ready
// WB     | register file write-back, instruction retires
// TRAP   | illegal opcode seen (option only); exit via rst only
module multicycle_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_write,
    output logic [1:0]         wb_sel,
    output logic               retire,
    output logic [CNT_W-1:0]   retire_cnt,
    output logic               illegal
);

    state_t     state;
    state_t     state_next;
    logic [2:0] alu_op_c;

    assign alu_op = ALUOP_W'(alu_op_c);

    // State register; reset lands in FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath controls; every output defaults to 0
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op_c   = ALU_FUNCT;
        reg_write  = 1'b0;
        wb_sel     = WB_ALUOUT;
        retire     = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                iord      = 1'b0;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                alu_op_c  = ALU_ADD;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_ALU;
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                alu_op_c  = ALU_ADD;
                if (op_known(op)) begin
                    state_next = S_EXEC;
                end else begin
`ifdef ILLEGAL_OP_TRAP_EN
                    state_next = S_TRAP;
`else
                    retire     = 1'b1;
                    state_next = S_FETCH;
`endif
                end
            end

            S_EXEC: begin
                case (op)
                    OP_R: begin
                        alu_src_a  = SRC_A_RS1;
                        alu_src_b  = SRC_B_RS2;
                        alu_op_c   = ALU_FUNCT;
                        state_next = S_WB;
                    end
                    OP_I: begin
                        alu_src_a  = SRC_A_RS1;
                        alu_src_b  = SRC_B_IMM;
                        alu_op_c   = ALU_FUNCT;
                        state_next = S_WB;
                    end
                    OP_LW: begin
                        alu_src_a  = SRC_A_RS1;
                        alu_src_b  = SRC_B_IMM;
                        alu_op_c   = ALU_LD;
                        state_next = S_MEM;
                    end
                    OP_SW: begin
                        alu_src_a  = SRC_A_RS1;
                        alu_src_b  = SRC_B_IMM;
                        alu_op_c   = ALU_ST;
                        state_next = S_MEM;
                    end
                    OP_LUI: begin
                        alu_src_b  = SRC_B_IMM;
                        alu_op_c   = ALU_PASSB;
                        state_next = S_WB;
                    end
                    OP_AUIPC: begin
                        alu_src_a  = SRC_A_OLDPC;
                        alu_src_b  = SRC_B_IMM;
                        alu_op_c   = ALU_ADD;
                        state_next = S_WB;
                    end
                    OP_BEQ: begin
                        // Target was computed in DECODE and sits in ALUOut
                        alu_src_a  = SRC_A_RS1;
                        alu_src_b  = SRC_B_RS2;
                        alu_op_c   = ALU_BR;
                        pc_write   = zero;
                        pc_src     = PC_SRC_ALUOUT;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_JAL: begin
                        // Link value is the already-incremented PC
                        pc_write   = 1'b1;
                        pc_src     = PC_SRC_ALUOUT;
                        reg_write  = 1'b1;
                        wb_sel     = WB_PC;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    default: begin
                        state_next = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (op == OP_SW);
                if (mem_ready) begin
                    if (op == OP_LW) begin
                        state_next = S_WB;
                    end else begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                wb_sel     = (op == OP_LW) ? WB_MEM : WB_ALUOUT;
                retire     = 1'b1;
                state_next = S_FETCH;
            end

`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP: begin
                state_next = S_TRAP;
            end
`endif

            default: begin
                state_next = S_FETCH;
            end
        endcase

        // While reset is held the FSM sits in FETCH, but no memory access
        // or architectural update may be launched from it.
        if (rst) begin
            mem_req  = 1'b0;
            ir_write = 1'b0;
            pc_write = 1'b0;
        end
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    // Sticky flag set on the edge that moves DECODE into TRAP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal <= 1'b0;
        end else if (state == S_DECODE && !op_known(op)) begin
            illegal <= 1'b1;
        end
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: a driver issues random
// instructions with random memory wait states and pushes the expected
// per-instruction behaviour; a monitor compares on every retire pulse.
module tb_multicycle_control_unit;
    import rv_ctrl_pkg::*;

    localparam int CNT_W  = 4;
    localparam int N_INSN = 45;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [6:0]       op = OP_R;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0]       pc_src, alu_src_a, alu_src_b, wb_sel;
    logic [2:0]       alu_op;
    logic             reg_write, retire, illegal;
    logic [CNT_W-1:0] retire_cnt;

    multicycle_control_unit #(.ALUOP_W(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .wb_sel(wb_sel), .retire(retire), .retire_cnt(retire_cnt),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         fw;
        int         lat;
        int         n_rw;
        int         n_we;
        int         n_req;
        int         n_pcw;
        int         wb_exp;
        int         exec_sig;
        int         cnt_before;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Behavioural expectations from the opcode table, latency rules and wait counts
    function automatic exp_t make_exp(input logic [6:0] o, input logic z,
                                      input int fw, input int mw, input int idx);
        exp_t e;
        bit is_mem = (o == OP_LW) || (o == OP_SW);
        int a = 0, b = 0, f = 0;
        e.fw = fw;
        case (o)
            OP_BEQ, OP_JAL:                   e.lat = 3;
            OP_LW:                            e.lat = 5;
            OP_R, OP_I, OP_LUI, OP_AUIPC, OP_SW: e.lat = 4;
            default:                          e.lat = 2;
        endcase
        e.lat   = e.lat + fw + (is_mem ? mw : 0);
        e.n_rw  = (o == OP_R || o == OP_I || o == OP_LW || o == OP_LUI ||
                   o == OP_AUIPC || o == OP_JAL) ? 1 : 0;
        e.n_we  = (o == OP_SW) ? mw + 1 : 0;
        e.n_req = fw + 1 + (is_mem ? mw + 1 : 0);
        e.n_pcw = 1 + ((o == OP_JAL || (o == OP_BEQ && z)) ? 1 : 0);
        e.wb_exp = (o == OP_LW) ? 1 : (o == OP_JAL) ? 2 : 0;
        case (o)
            OP_R:     begin a = 2; b = 0; f = 0; end
            OP_I:     begin a = 2; b = 2; f = 0; end
            OP_LW:    begin a = 2; b = 2; f = 1; end
            OP_SW:    begin a = 2; b = 2; f = 2; end
            OP_LUI:   begin a = 0; b = 2; f = 4; end
            OP_AUIPC: begin a = 1; b = 2; f = 5; end
            OP_BEQ:   begin a = 2; b = 0; f = 3; end
            default:  begin a = 0; b = 0; f = 0; end
        endcase
        e.exec_sig   = a * 32 + b * 8 + f;
        e.cnt_before = idx % (1 << CNT_W);
        return e;
    endfunction

    // Monitor: per-cycle field checks, per-instruction totals on retire
    initial begin
        int   cyc = 0, rw = 0, we = 0, rq = 0, pcw = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en || rst || q.size() == 0) begin
                if (mon_en && !rst && retire) chk("unexpected_retire", 1, 0);
                cyc = 0; rw = 0; we = 0; rq = 0; pcw = 0;
            end else begin
                e = q[0];
                if (cyc <= e.fw)
                    chk("fetch_sig", {alu_src_a, alu_src_b, alu_op, iord}, {2'd0, 2'd1, 3'd5, 1'b0});
                else if (cyc == e.fw + 1)
                    chk("decode_sig", {alu_src_a, alu_src_b, alu_op}, {2'd1, 2'd2, 3'd5});
                else if (cyc == e.fw + 2 && e.lat > e.fw + 2)
                    chk("exec_sig", {alu_src_a, alu_src_b, alu_op}, e.exec_sig);
                if (mem_we && !mem_req) chk("we_without_req", 1, 0);
                if (reg_write) chk("wb_sel", wb_sel, e.wb_exp);
                if (pc_write) chk("pc_src", pc_src, (cyc <= e.fw) ? 0 : 1);
                rw += reg_write; we += mem_we; rq += mem_req; pcw += pc_write;
                cyc++;
                if (retire) begin
                    chk("latency", cyc, e.lat);
                    chk("reg_write_cycles", rw, e.n_rw);
                    chk("mem_we_cycles", we, e.n_we);
                    chk("mem_req_cycles", rq, e.n_req);
                    chk("pc_write_cycles", pcw, e.n_pcw);
                    chk("retire_cnt", retire_cnt, e.cnt_before);
`ifndef ILLEGAL_OP_TRAP_EN
                    chk("illegal_tied", illegal, 0);
`endif
                    void'(q.pop_front());
                    cyc = 0; rw = 0; we = 0; rq = 0; pcw = 0;
                end else if (cyc > 60) begin
                    chk("retire_timeout", cyc, e.lat);
                    void'(q.pop_front());
                    cyc = 0; rw = 0; we = 0; rq = 0; pcw = 0;
                end
            end
        end
    end

    // Serve one memory request with n wait cycles; called at a negedge
    task automatic handshake(input int n);
        int guard = 0;
        int left = n;
        while (guard < 100) begin
            if (mem_req) begin
                if (left > 0) begin
                    mem_ready = 1'b0;
                    left--;
                    @(negedge clk);
                end else begin
                    mem_ready = 1'b1;
                    @(negedge clk);
                    mem_ready = 1'b0;
                    return;
                end
            end else begin
                mem_ready = 1'b0;
                @(negedge clk);
            end
            guard++;
        end
        chk("handshake_timeout", guard, 0);
    endtask

    // Wait at negedges until the FSM is back in FETCH
    task automatic wait_fetch();
        int guard = 0;
        while (!(mem_req && !iord) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("fetch_timeout", guard, 0);
    endtask

    logic [6:0] op_tab [9];

    initial begin
        int sel, fw, mw, guard;
        logic z;
        op_tab[0] = OP_R;   op_tab[1] = OP_I;     op_tab[2] = OP_LW;
        op_tab[3] = OP_SW;  op_tab[4] = OP_BEQ;   op_tab[5] = OP_LUI;
        op_tab[6] = OP_AUIPC; op_tab[7] = OP_JAL; op_tab[8] = 7'b1111111;

        // Reset state, with mem_ready high to show strobes are suppressed
        rst = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_alu_src_b", alu_src_b, 1);
        chk("rst_alu_op", alu_op, 5);
        chk("rst_retire_cnt", retire_cnt, 0);
        chk("rst_illegal", illegal, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b0;
        mon_en = 1;
        @(negedge clk);

        for (int i = 0; i < N_INSN; i++) begin
            wait_fetch();
`ifdef ILLEGAL_OP_TRAP_EN
            sel = $urandom_range(0, 7);
`else
            sel = (i < 8) ? i : $urandom_range(0, 8);
            if (i == 8) sel = 8;
`endif
            z  = 1'($urandom_range(0, 1));
            if (i == 4) z = 1'b1;
            if (i == 12) begin sel = 4; z = 1'b0; end
            fw = $urandom_range(0, 2);
            mw = (i == 2) ? 2 : $urandom_range(0, 2);
            op = op_tab[sel];
            zero = z;
            q.push_back(make_exp(op_tab[sel], z, fw, mw, i));
            handshake(fw);
            if (op_tab[sel] == OP_LW || op_tab[sel] == OP_SW) handshake(mw);
        end
        wait_fetch();
        #3;
        chk("queue_drained", q.size(), 0);
        chk("count_before_reset", retire_cnt, N_INSN % (1 << CNT_W));

        // Reset asserted in the middle of a load's MEM wait
        mon_en = 0;
        @(negedge clk);
        op = OP_LW;
        handshake(0);
        guard = 0;
        mem_ready = 1'b0;
        while (!(mem_req && iord) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_mem", guard < 20, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_iord", iord, 0);
        chk("midrst_alu_src_b", alu_src_b, 1);
        chk("midrst_alu_op", alu_op, 5);
        chk("midrst_retire_cnt", retire_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("post_rst_fetch_req", mem_req, 1);
        chk("post_rst_retire_cnt", retire_cnt, 0);

`ifdef ILLEGAL_OP_TRAP_EN
        @(negedge clk);
        op = 7'b1111111;
        handshake(0);
        repeat (2) @(negedge clk);
        #2;
        chk("trap_illegal", illegal, 1);
        chk("trap_mem_req", mem_req, 0);
        mem_ready = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        chk("trap_stuck_req", mem_req, 0);
        chk("trap_no_retire", retire_cnt, 0);
        chk("trap_sticky", illegal, 1);
        mem_ready = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
